// File: rtl/ctrl_unit_pipe_if.sv
// Handshake and control-word bundle between the fetch buffer, ctrl_unit_pipe and execute.
// slave = the control unit, master = its environment.
interface ctrl_unit_pipe_if #(parameter int CNT_W = 16);
    logic [31:0]      instr;
    logic             in_valid;
    logic             in_ready;
    logic             flush;
    logic             out_ready;
    logic             out_valid;
    logic             reg_write;
    logic [1:0]       mem_reg;
    logic [2:0]       imm_sel;
    logic             operand_a;
    logic             operand_b;
    logic [3:0]       alu_control;
    logic             mem_en;
    logic             s;
    logic             l;
    logic             sb;
    logic             uj;
    logic             jalr_i;
    logic             u_aui;
    logic             u_lui;
    logic [4:0]       rd;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic             illegal;
    logic             m_op;
    logic [CNT_W-1:0] stall_cnt;

    modport slave (
        input  instr, in_valid, flush, out_ready,
        output in_ready, out_valid, reg_write, mem_reg, imm_sel, operand_a, operand_b,
               alu_control, mem_en, s, l, sb, uj, jalr_i, u_aui, u_lui, rd, rs1, rs2,
               illegal, m_op, stall_cnt
    );

    modport master (
        output instr, in_valid, flush, out_ready,
        input  in_ready, out_valid, reg_write, mem_reg, imm_sel, operand_a, operand_b,
               alu_control, mem_en, s, l, sb, uj, jalr_i, u_aui, u_lui, rd, rs1, rs2,
               illegal, m_op, stall_cnt
    );
endinterface

// File: rtl/ctrl_unit_pipe.sv
// RV32I control unit: combinational decode feeding a DEPTH-stage elastic pipeline with
// load-use stalling, flush and a saturating stall counter. Define RV32M_EN for M-extension decode.
module ctrl_unit_pipe #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    ctrl_unit_pipe_if.slave  bus
);
    typedef struct packed {
        logic       reg_write;
        logic [1:0] mem_reg;
        logic [2:0] imm_sel;
        logic       operand_a;
        logic       operand_b;
        logic [3:0] alu_control;
        logic       mem_en;
        logic       s;
        logic       l;
        logic       sb;
        logic       uj;
        logic       jalr_i;
        logic       u_aui;
        logic       u_lui;
        logic       illegal;
        logic       m_op;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
    } ctrl_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    logic [6:0]       opcode;
    logic [2:0]       funct3;
    logic [6:0]       funct7;
    ctrl_t            dec;
    logic             uses_rs1;
    logic             uses_rs2;
    logic             hazard;
    logic             accept;
    logic             chain;
    logic [DEPTH-1:0] valid;
    logic [DEPTH-1:0] load;
    logic [DEPTH-1:0] in_v;
    ctrl_t            data    [DEPTH];
    ctrl_t            in_data [DEPTH];
    ctrl_t            q;
    logic [CNT_W-1:0] stall_cnt;

    assign opcode = bus.instr[6:0];
    assign funct3 = bus.instr[14:12];
    assign funct7 = bus.instr[31:25];

    always_comb begin
        dec     = '0;
        dec.rd  = bus.instr[11:7];
        dec.rs1 = bus.instr[19:15];
        dec.rs2 = bus.instr[24:20];
        case (opcode)
            OP_R: begin
                if (funct7 == 7'b0000001) begin
`ifdef RV32M_EN
                    dec.m_op        = 1'b1;
                    dec.reg_write   = 1'b1;
                    dec.alu_control = {1'b0, funct3};
`else
                    dec.illegal     = 1'b1;
`endif
                end else begin
                    dec.reg_write   = 1'b1;
                    dec.alu_control = {bus.instr[30], funct3};
                end
            end
            OP_I: begin
                dec.reg_write   = 1'b1;
                dec.operand_b   = 1'b1;
                dec.alu_control = {(funct3 == 3'b001 || funct3 == 3'b101) ? bus.instr[30] : 1'b0, funct3};
            end
            OP_LOAD: begin
                dec.reg_write = 1'b1;
                dec.mem_reg   = 2'b01;
                dec.operand_b = 1'b1;
                dec.mem_en    = 1'b1;
                dec.l         = 1'b1;
            end
            OP_STORE: begin
                dec.imm_sel   = 3'b001;
                dec.operand_b = 1'b1;
                dec.mem_en    = 1'b1;
                dec.s         = 1'b1;
            end
            OP_BRANCH: begin
                dec.imm_sel   = 3'b010;
                dec.operand_a = 1'b1;
                dec.operand_b = 1'b1;
                dec.sb        = 1'b1;
            end
            OP_JAL: begin
                dec.reg_write = 1'b1;
                dec.mem_reg   = 2'b10;
                dec.imm_sel   = 3'b100;
                dec.operand_a = 1'b1;
                dec.operand_b = 1'b1;
                dec.uj        = 1'b1;
            end
            OP_JALR: begin
                dec.reg_write = 1'b1;
                dec.mem_reg   = 2'b10;
                dec.operand_b = 1'b1;
                dec.jalr_i    = 1'b1;
            end
            OP_AUIPC: begin
                dec.reg_write = 1'b1;
                dec.imm_sel   = 3'b011;
                dec.operand_a = 1'b1;
                dec.operand_b = 1'b1;
                dec.u_aui     = 1'b1;
            end
            OP_LUI: begin
                dec.reg_write = 1'b1;
                dec.imm_sel   = 3'b011;
                dec.operand_b = 1'b1;
                dec.u_lui     = 1'b1;
            end
            default: dec.illegal = 1'b1;
        endcase
    end

    // Only a load sitting in stage 0 is too young to forward from, so only it can stall.
    always_comb begin
        uses_rs1 = opcode inside {OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JALR};
        uses_rs2 = opcode inside {OP_R, OP_STORE, OP_BRANCH};
        hazard   = valid[0] && data[0].l && (data[0].rd != 5'd0) &&
                   ((uses_rs1 && data[0].rd == dec.rs1) || (uses_rs2 && data[0].rd == dec.rs2));
    end

    // A stage may load when it or any stage after it has a hole, or the output drains.
    always_comb begin
        load  = '0;
        chain = bus.out_ready;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            chain   = chain | ~valid[i];
            load[i] = chain;
        end
    end

    assign bus.in_ready = rst_n & load[0] & ~hazard & ~bus.flush;
    assign accept       = bus.in_valid & bus.in_ready;

    always_comb begin
        in_v       = '0;
        in_v[0]    = accept;
        in_data[0] = dec;
        for (int i = 1; i < DEPTH; i++) begin
            in_v[i]    = valid[i-1];
            in_data[i] = data[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= '0;
            for (int i = 0; i < DEPTH; i++) data[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (bus.flush)   valid[i] <= 1'b0;
                else if (load[i]) valid[i] <= in_v[i];
                if (load[i] && in_v[i]) data[i] <= in_data[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cnt <= '0;
        else if (bus.in_valid && hazard && stall_cnt != {CNT_W{1'b1}})
            stall_cnt <= stall_cnt + 1'b1;
    end

    assign q               = data[DEPTH-1];
    assign bus.out_valid   = valid[DEPTH-1];
    assign bus.reg_write   = q.reg_write;
    assign bus.mem_reg     = q.mem_reg;
    assign bus.imm_sel     = q.imm_sel;
    assign bus.operand_a   = q.operand_a;
    assign bus.operand_b   = q.operand_b;
    assign bus.alu_control = q.alu_control;
    assign bus.mem_en      = q.mem_en;
    assign bus.s           = q.s;
    assign bus.l           = q.l;
    assign bus.sb          = q.sb;
    assign bus.uj          = q.uj;
    assign bus.jalr_i      = q.jalr_i;
    assign bus.u_aui       = q.u_aui;
    assign bus.u_lui       = q.u_lui;
    assign bus.illegal     = q.illegal;
    assign bus.m_op        = q.m_op;
    assign bus.rd          = q.rd;
    assign bus.rs1         = q.rs1;
    assign bus.rs2         = q.rs2;
    assign bus.stall_cnt   = stall_cnt;
endmodule

// File: tb/tb_ctrl_unit_pipe.sv
// Directed self-checking bench for ctrl_unit_pipe (DEPTH=2); define RV32M_EN to match an M-enabled build.
module tb_ctrl_unit_pipe;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   exp_stall;

    ctrl_unit_pipe_if #(.CNT_W(16)) bus ();

    ctrl_unit_pipe #(.DEPTH(2), .CNT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] addi(input logic [4:0] rd, input logic [11:0] imm);
        return {imm, 5'd0, 3'b000, rd, 7'b0010011};
    endfunction

    task automatic idle_drain();
        bus.in_valid  = 1'b0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;
        repeat (4) tick();
    endtask

    task automatic test_reset();
        #3;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", bus.in_ready); end
        checks++; if (bus.stall_cnt !== 16'd0) begin errors++; $display("FAIL reset_stall_cnt got %0d want 0", bus.stall_cnt); end
        checks++; if (bus.reg_write !== 1'b0 || bus.rd !== 5'd0) begin errors++; $display("FAIL reset_word got rw=%b rd=%0d want 0/0", bus.reg_write, bus.rd); end
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
    endtask

    task automatic test_add();
        bus.out_ready = 1'b1;
        bus.instr     = 32'h002081B3;
        bus.in_valid  = 1'b1;
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL add_in_ready got %b want 1", bus.in_ready); end
        tick();
        bus.in_valid = 1'b0;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL add_early_valid got %b want 0", bus.out_valid); end
        tick();
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL add_out_valid got %b want 1", bus.out_valid); end
        checks++; if (bus.reg_write !== 1'b1 || bus.alu_control !== 4'b0000 || bus.operand_b !== 1'b0 || bus.rd !== 5'd3)
            begin errors++; $display("FAIL add_word got rw=%b alu=%b opb=%b rd=%0d want 1/0000/0/3", bus.reg_write, bus.alu_control, bus.operand_b, bus.rd); end
        checks++; if (bus.rs1 !== 5'd1 || bus.rs2 !== 5'd2 || bus.mem_reg !== 2'b00 || bus.illegal !== 1'b0)
            begin errors++; $display("FAIL add_regs got rs1=%0d rs2=%0d mr=%b ill=%b want 1/2/00/0", bus.rs1, bus.rs2, bus.mem_reg, bus.illegal); end
        tick();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL add_drained got %b want 0", bus.out_valid); end
    endtask

    task automatic test_load_use();
        bus.out_ready = 1'b1;
        bus.instr     = 32'h0000A283;
        bus.in_valid  = 1'b1;
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL lu_lw_ready got %b want 1", bus.in_ready); end
        tick();
        bus.instr = 32'h00228333;
        #1;
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL lu_stall got in_ready=%b want 0", bus.in_ready); end
        tick();
        exp_stall++;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL lu_release got in_ready=%b want 1", bus.in_ready); end
        checks++; if (bus.stall_cnt !== 16'(exp_stall)) begin errors++; $display("FAIL lu_stall_cnt got %0d want %0d", bus.stall_cnt, exp_stall); end
        checks++; if (bus.out_valid !== 1'b1 || bus.l !== 1'b1 || bus.rd !== 5'd5 || bus.mem_reg !== 2'b01)
            begin errors++; $display("FAIL lu_lw_out got v=%b l=%b rd=%0d mr=%b want 1/1/5/01", bus.out_valid, bus.l, bus.rd, bus.mem_reg); end
        tick();
        bus.in_valid = 1'b0;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL lu_bubble got %b want 0", bus.out_valid); end
        tick();
        checks++; if (bus.out_valid !== 1'b1 || bus.rd !== 5'd6 || bus.rs1 !== 5'd5 || bus.l !== 1'b0)
            begin errors++; $display("FAIL lu_add_out got v=%b rd=%0d rs1=%0d l=%b want 1/6/5/0", bus.out_valid, bus.rd, bus.rs1, bus.l); end
        checks++; if (bus.stall_cnt !== 16'(exp_stall)) begin errors++; $display("FAIL lu_cnt_hold got %0d want %0d", bus.stall_cnt, exp_stall); end
        idle_drain();
    endtask

    task automatic test_back_to_back();
        logic [31:0] prog  [4];
        logic [3:0]  e_alu [4];
        logic [4:0]  e_rd  [4];
        logic        e_s   [4];
        prog[0] = 32'h40208233; e_alu[0] = 4'b1000; e_rd[0] = 5'd4; e_s[0] = 1'b0;
        prog[1] = 32'h4030D393; e_alu[1] = 4'b1101; e_rd[1] = 5'd7; e_s[1] = 1'b0;
        prog[2] = 32'h40000413; e_alu[2] = 4'b0000; e_rd[2] = 5'd8; e_s[2] = 1'b0;
        prog[3] = 32'h0020A223; e_alu[3] = 4'b0000; e_rd[3] = 5'd4; e_s[3] = 1'b1;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            bus.in_valid = (c < 4);
            bus.instr    = (c < 4) ? prog[c] : 32'h0;
            #1;
            if (c < 4) begin
                checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d] got %b want 1", c, bus.in_ready); end
            end
            if (c >= 2) begin
                checks++;
                if (bus.out_valid !== 1'b1 || bus.alu_control !== e_alu[c-2] || bus.rd !== e_rd[c-2] || bus.s !== e_s[c-2]) begin
                    errors++;
                    $display("FAIL b2b_out[%0d] got v=%b alu=%b rd=%0d s=%b want 1/%b/%0d/%b",
                             c-2, bus.out_valid, bus.alu_control, bus.rd, bus.s, e_alu[c-2], e_rd[c-2], e_s[c-2]);
                end
            end
            if (c == 5) begin
                checks++; if (bus.imm_sel !== 3'b001 || bus.mem_en !== 1'b1 || bus.reg_write !== 1'b0 || bus.operand_b !== 1'b1)
                    begin errors++; $display("FAIL b2b_store got imm=%b men=%b rw=%b opb=%b want 001/1/0/1", bus.imm_sel, bus.mem_en, bus.reg_write, bus.operand_b); end
            end
            tick();
        end
        idle_drain();
    endtask

    task automatic test_backpressure();
        int   tx;
        int   rx;
        logic held;
        logic [4:0] held_rd;
        logic acc;
        logic hs;
        tx = 0; rx = 0; held = 1'b0; held_rd = '0;
        for (int cyc = 0; cyc < 100 && rx < 8; cyc++) begin
            bus.out_ready = (cyc % 2 == 0);
            bus.in_valid  = (tx < 8);
            bus.instr     = addi(5'(tx + 1), 12'(tx + 1));
            #1;
            if (held) begin
                checks++; if (bus.out_valid !== 1'b1 || bus.rd !== held_rd)
                    begin errors++; $display("FAIL bp_stable got v=%b rd=%0d want 1/%0d", bus.out_valid, bus.rd, held_rd); end
            end
            acc = bus.in_valid & bus.in_ready;
            hs  = bus.out_valid & bus.out_ready;
            if (hs) begin
                checks++; if (bus.rd !== 5'(rx + 1) || bus.alu_control !== 4'b0000 || bus.operand_b !== 1'b1)
                    begin errors++; $display("FAIL bp_order got rd=%0d alu=%b opb=%b want %0d/0000/1", bus.rd, bus.alu_control, bus.operand_b, rx + 1); end
                rx++;
            end
            held    = bus.out_valid & ~bus.out_ready;
            held_rd = bus.rd;
            if (acc) tx++;
            tick();
        end
        checks++; if (rx != 8) begin errors++; $display("FAIL bp_count got %0d want 8", rx); end
        idle_drain();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_no_dup got out_valid=%b want 0", bus.out_valid); end
    endtask

    task automatic test_flush();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.instr     = addi(5'd1, 12'd1);
        tick();
        bus.instr = addi(5'd2, 12'd2);
        tick();
        bus.instr = addi(5'd3, 12'd3);
        #1;
        checks++; if (bus.out_valid !== 1'b1 || bus.rd !== 5'd1 || bus.in_ready !== 1'b0)
            begin errors++; $display("FAIL fl_full got v=%b rd=%0d rdy=%b want 1/1/0", bus.out_valid, bus.rd, bus.in_ready); end
        bus.out_ready = 1'b1;
        bus.flush     = 1'b1;
        #1;
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL fl_in_ready got %b want 0", bus.in_ready); end
        tick();
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL fl_cleared got %b want 0", bus.out_valid); end
        tick();
        tick();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL fl_not_accepted got %b want 0", bus.out_valid); end
        idle_drain();
    endtask

    task automatic test_illegal();
        bus.out_ready = 1'b1;
        bus.instr     = 32'h0000007F;
        bus.in_valid  = 1'b1;
        tick();
        bus.instr = 32'h023100B3;
        tick();
        bus.in_valid = 1'b0;
        checks++; if (bus.out_valid !== 1'b1 || bus.illegal !== 1'b1 || bus.reg_write !== 1'b0 || bus.mem_en !== 1'b0 || bus.operand_b !== 1'b0)
            begin errors++; $display("FAIL ill_word got v=%b ill=%b rw=%b men=%b opb=%b want 1/1/0/0/0", bus.out_valid, bus.illegal, bus.reg_write, bus.mem_en, bus.operand_b); end
        tick();
`ifdef RV32M_EN
        checks++; if (bus.out_valid !== 1'b1 || bus.m_op !== 1'b1 || bus.illegal !== 1'b0 || bus.reg_write !== 1'b1 || bus.alu_control !== 4'b0000 || bus.rd !== 5'd1)
            begin errors++; $display("FAIL mul_word got v=%b m=%b ill=%b rw=%b alu=%b rd=%0d want 1/1/0/1/0000/1", bus.out_valid, bus.m_op, bus.illegal, bus.reg_write, bus.alu_control, bus.rd); end
`else
        checks++; if (bus.out_valid !== 1'b1 || bus.m_op !== 1'b0 || bus.illegal !== 1'b1 || bus.reg_write !== 1'b0)
            begin errors++; $display("FAIL mul_word got v=%b m=%b ill=%b rw=%b want 1/0/1/0", bus.out_valid, bus.m_op, bus.illegal, bus.reg_write); end
`endif
        idle_drain();
    endtask

    task automatic test_reset_mid();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.instr     = addi(5'd5, 12'd5);
        tick();
        bus.instr = addi(5'd6, 12'd6);
        tick();
        checks++; if (bus.out_valid !== 1'b1 || bus.stall_cnt !== 16'(exp_stall))
            begin errors++; $display("FAIL rm_before got v=%b cnt=%0d want 1/%0d", bus.out_valid, bus.stall_cnt, exp_stall); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0 || bus.reg_write !== 1'b0 || bus.rd !== 5'd0 || bus.operand_b !== 1'b0)
            begin errors++; $display("FAIL rm_outputs got v=%b rdy=%b rw=%b rd=%0d opb=%b want all 0", bus.out_valid, bus.in_ready, bus.reg_write, bus.rd, bus.operand_b); end
        checks++; if (bus.stall_cnt !== 16'd0) begin errors++; $display("FAIL rm_stall_cnt got %0d want 0", bus.stall_cnt); end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rm_discarded got %b want 0", bus.out_valid); end
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        exp_stall     = 0;
        rst_n         = 1'b0;
        bus.instr     = 32'h0;
        bus.in_valid  = 1'b0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        test_reset();
        test_add();
        test_load_use();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_illegal();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
